// File: rtl/sram_ctrl_if.sv
// CPU-side request/response bus of the SRAM controller.
// The CPU side uses the master modport; sram_ctrl uses the slave modport.
interface sram_ctrl_if #(
  parameter int unsigned ADDR_W = 20
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_be;
  logic [15:0]       req_wdata;
  logic              rsp_valid;
  logic [15:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_ctrl.sv
// Responder for the CPU memory bus. It runs one timed access at a time on an
// external async 16-bit SRAM. All SRAM pins and the response are registered.
module sram_ctrl #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2,
  parameter int unsigned TURN    = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in
);

  localparam int unsigned MAX_RW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int unsigned MAX_W  = (MAX_RW > TURN) ? MAX_RW : TURN;
  localparam int unsigned CNT_W  = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_TURN,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [1:0]         be_q, be_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [15:0]        dq_out_d, rdata_d;
  logic               rvalid_d;
  logic               ce_d, oe_d, we_d, ub_d, lb_d, dqoe_d;

  assign bus.req_ready = (state == S_IDLE) & ~Reset;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    be_d     = be_q;
    addr_d   = sram_addr;
    dq_out_d = sram_dq_out;
    rdata_d  = bus.rsp_rdata;
    rvalid_d = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          be_d   = bus.req_be;
          if (bus.req_we) dq_out_d = bus.req_wdata;
          // Zero byte enables: no SRAM cycle; reads answer zero, writes vanish.
          if (bus.req_be == 2'b00) begin
            if (!bus.req_we) begin
              rvalid_d = 1'b1;
              rdata_d  = '0;
            end
          end else if (!bus.req_we) begin
            state_d = S_RD;
            cnt_d   = CNT_W'(RD_WAIT);
          end else if (bus.rsp_valid && (TURN != 0)) begin
            state_d = S_TURN;
            cnt_d   = CNT_W'(TURN);
          end else begin
            state_d = S_WR_SETUP;
          end
        end
      end
      S_RD: begin
        if (cnt == CNT_W'(1)) begin
          rdata_d  = {sram_dq_in[15:8] & {8{be_q[1]}}, sram_dq_in[7:0] & {8{be_q[0]}}};
          rvalid_d = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_TURN: begin
        if (cnt == CNT_W'(1)) begin
          state_d = S_WR_SETUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = CNT_W'(WR_WAIT);
      end
      S_WR_PULSE: begin
        if (cnt == CNT_W'(1)) begin
          state_d = S_WR_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_WR_HOLD: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Pins are registered, so they are decoded from the state being entered.
    ce_d   = 1'b1;
    oe_d   = 1'b1;
    we_d   = 1'b1;
    ub_d   = 1'b1;
    lb_d   = 1'b1;
    dqoe_d = 1'b0;
    case (state_d)
      S_RD: begin
        ce_d = 1'b0;
        oe_d = 1'b0;
        ub_d = ~be_d[1];
        lb_d = ~be_d[0];
      end
      S_WR_SETUP, S_WR_HOLD: begin
        ce_d   = 1'b0;
        ub_d   = ~be_d[1];
        lb_d   = ~be_d[0];
        dqoe_d = 1'b1;
      end
      S_WR_PULSE: begin
        ce_d   = 1'b0;
        we_d   = 1'b0;
        ub_d   = ~be_d[1];
        lb_d   = ~be_d[0];
        dqoe_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      be_q          <= '0;
      sram_addr     <= '0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_ub_n     <= 1'b1;
      sram_lb_n     <= 1'b1;
      sram_dq_out   <= '0;
      sram_dq_oe    <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      be_q          <= be_d;
      sram_addr     <= addr_d;
      sram_ce_n     <= ce_d;
      sram_oe_n     <= oe_d;
      sram_we_n     <= we_d;
      sram_ub_n     <= ub_d;
      sram_lb_n     <= lb_d;
      sram_dq_out   <= dq_out_d;
      sram_dq_oe    <= dqoe_d;
      bus.rsp_valid <= rvalid_d;
      bus.rsp_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: directed scenarios then random traffic, checked against
// a transaction-level memory model and per-access cycle counts.
module tb_sram_ctrl;

  localparam int unsigned AW = 20;
  localparam int unsigned RD_WAIT = 2;
  localparam int unsigned WR_WAIT = 2;
  localparam int unsigned TURN = 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [AW-1:0] sram_addr;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;

  sram_ctrl_if #(.ADDR_W(AW)) bus ();

  sram_ctrl #(
    .ADDR_W (AW),
    .RD_WAIT(RD_WAIT),
    .WR_WAIT(WR_WAIT),
    .TURN   (TURN)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .bus        (bus),
    .sram_addr  (sram_addr),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in)
  );

  always #5 Clk = ~Clk;

  // Async SRAM device: low address byte selects the word.
  logic [15:0] sram_mem [0:255];
  always_comb sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[7:0]] : 16'hDEAD;
  always @(posedge Clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_ub_n) sram_mem[sram_addr[7:0]][15:8] <= sram_dq_out[15:8];
      if (!sram_lb_n) sram_mem[sram_addr[7:0]][7:0]  <= sram_dq_out[7:0];
    end
  end

  int unsigned   total = 0;
  int unsigned   bad = 0;
  logic [15:0]   ref_mem [0:255];
  logic          rsp_now = 1'b0;
  logic [AW-1:0] pool [0:7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One request, issued in the current cycle; returns in the cycle req_ready is back.
  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [1:0] be,
                     input logic [15:0] wd);
    int unsigned busy = 0, oe_lo = 0, we_lo = 0, dqoe = 0, rsp_cnt = 0, rsp_at = 0;
    int unsigned idle_busy = 0, lane_err = 0, inv = 0;
    logic        done = 1'b0;
    logic [15:0] rdata_seen = '0;
    logic        act = (be != 2'b00);
    logic        exp_turn = we && act && rsp_now && (TURN != 0);
    logic [15:0] exp_rd = {ref_mem[addr[7:0]][15:8] & {8{be[1]}}, ref_mem[addr[7:0]][7:0] & {8{be[0]}}};

    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_be    = be;
    bus.req_wdata = wd;
    chk("ready_at_accept", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_wdata = 16'($urandom);

    for (int c = 1; c <= 40 && !done; c++) begin
      if (!bus.req_ready) busy++; else done = 1'b1;
      if (!sram_oe_n) oe_lo++;
      if (!sram_we_n) we_lo++;
      if (sram_dq_oe) dqoe++;
      if (bus.rsp_valid) begin
        rsp_cnt++;
        rsp_at = c;
        rdata_seen = bus.rsp_rdata;
      end
      if (!bus.req_ready && ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} == 5'b11111)
          && !sram_dq_oe) idle_busy++;
      if (!sram_ce_n && (sram_ub_n !== ~be[1] || sram_lb_n !== ~be[0] || sram_addr !== addr))
        lane_err++;
      if ((!sram_oe_n && !sram_we_n) || (sram_dq_oe && !sram_oe_n)) inv++;
      if (!done) tick();
    end

    chk("completes", done, 1);
    chk("lanes_addr", lane_err, 0);
    chk("strobe_overlap", inv, 0);
    chk("turn_cycles", idle_busy, exp_turn ? TURN : 0);
    if (we) begin
      chk("wr_busy", busy, act ? 2 + WR_WAIT + (exp_turn ? TURN : 0) : 0);
      chk("wr_we_low", we_lo, act ? WR_WAIT : 0);
      chk("wr_dq_oe", dqoe, act ? 2 + WR_WAIT : 0);
      chk("wr_no_rsp", rsp_cnt, 0);
      if (act) begin
        if (be[1]) ref_mem[addr[7:0]][15:8] = wd[15:8];
        if (be[0]) ref_mem[addr[7:0]][7:0]  = wd[7:0];
      end
    end else begin
      chk("rd_busy", busy, act ? RD_WAIT : 0);
      chk("rd_oe_low", oe_lo, act ? RD_WAIT : 0);
      chk("rd_we_low", we_lo, 0);
      chk("rd_rsp_cnt", rsp_cnt, 1);
      chk("rd_rsp_at", rsp_at, act ? RD_WAIT + 1 : 1);
      chk("rd_data", rdata_seen, act ? exp_rd : 16'h0000);
    end
    rsp_now = !we;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_wdata = '0;

    // Reset for 3 cycles, then check the first cycle after release.
    Reset = 1'b1;
    repeat (3) tick();
    chk("ready_in_reset", bus.req_ready, 0);
    Reset = 1'b0;
    tick();
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_ready", bus.req_ready, 1);

    // Directed: write, full read, byte-lane read, read->write turnaround.
    txn(1'b1, 20'h00012, 2'b11, 16'hBEEF);
    txn(1'b0, 20'h00012, 2'b11, 16'h0000);
    txn(1'b0, 20'h00012, 2'b01, 16'h0000);
    txn(1'b0, 20'h00012, 2'b11, 16'h0000);
    txn(1'b1, 20'h00034, 2'b11, 16'h1234);
    txn(1'b0, 20'h00034, 2'b10, 16'h0000);
    txn(1'b0, 20'h00034, 2'b00, 16'h0000);
    txn(1'b1, 20'h00034, 2'b11, 16'h5678);

    // Reset during the second RD cycle aborts the read.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 20'h00012;
    bus.req_be    = 2'b11;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("abort_in_rd", sram_oe_n, 0);
    Reset = 1'b1;
    tick();
    chk("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
    chk("abort_dq_oe", sram_dq_oe, 0);
    chk("abort_no_rsp", bus.rsp_valid, 0);
    Reset = 1'b0;
    tick();
    chk("abort_ready", bus.req_ready, 1);
    chk("abort_no_rsp_late", bus.rsp_valid, 0);
    rsp_now = 1'b0;

    // Random traffic over a small address pool with distinct low bytes.
    for (int i = 0; i < 8; i++) begin
      pool[i] = {12'($urandom), 8'(8'h40 + i)};
      txn(1'b1, pool[i], 2'b11, 16'($urandom));
    end
    for (int i = 0; i < 80; i++) begin
      txn(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
          2'($urandom_range(0, 3)), 16'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        tick();
        rsp_now = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
